// File: rtl/vga_syncgen_param.sv
// Parametrised VGA sync and test-pattern generator with internal pixel clock-enable.
// Ports: clk, rst_n (async low), i_mode, i_solid_rgb -> o_hsync, o_vsync, o_r/g/b, o_vga_act, o_hcnt, o_vcnt, o_frame_start.
module vga_syncgen_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             i_mode,
    input  logic [3*COLOR_W-1:0]   i_solid_rgb,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic [COLOR_W-1:0]     o_r,
    output logic [COLOR_W-1:0]     o_g,
    output logic [COLOR_W-1:0]     o_b,
    output logic                   o_vga_act,
    output logic [HW-1:0]          o_hcnt,
    output logic [VW-1:0]          o_vcnt,
    output logic                   o_frame_start
);

    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int H_S0  = H_ACTIVE + H_FP;
    localparam int H_S1  = H_S0 + H_SYNC;
    localparam int V_S0  = V_ACTIVE + V_FP;
    localparam int V_S1  = V_S0 + V_SYNC;

    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    logic [DW-1:0]          div_q, div_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [VW-1:0]          vcnt_q, vcnt_d;
    logic [BCW-1:0]         bpos_q, bpos_d;
    logic [2:0]             bar_q, bar_d;
    logic [1:0]             mode_q, mode_d;
    logic [3*COLOR_W-1:0]   solid_q, solid_d;
    logic                   pen, first, act, hs, vs, chk;
    logic [31:0]            hx, vx;
    logic [COLOR_W-1:0]     r_d, g_d, b_d;
    logic [COLOR_W-1:0]     r_q, g_q, b_q;
    logic                   hsync_q, vsync_q, act_q, fs_q;
    logic [HW-1:0]          hout_q;
    logic [VW-1:0]          vout_q;

    always_comb begin
        pen    = (div_q == DIV_LAST);
        div_d  = pen ? '0 : div_q + 1'b1;
        hx     = 32'(hcnt_q);
        vx     = 32'(vcnt_q);
        hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end

        // Bar index follows hcnt by counting pixels within a bar.
        bpos_d = bpos_q + 1'b1;
        bar_d  = bar_q;
        if (hcnt_q == H_LAST) begin
            bpos_d = '0;
            bar_d  = '0;
        end else if (bpos_q == BAR_LAST) begin
            bpos_d = '0;
            bar_d  = bar_q + 1'b1;
        end

        // Pixel (0,0) already uses the freshly latched pattern source.
        first   = (hcnt_q == '0) && (vcnt_q == '0);
        mode_d  = first ? i_mode : mode_q;
        solid_d = first ? i_solid_rgb : solid_q;

        act = (hx < H_ACTIVE) && (vx < V_ACTIVE);
        hs  = (hx >= H_S0) && (hx < H_S1);
        vs  = (vx >= V_S0) && (vx < V_S1);
        chk = hx[CHK_LOG2] ^ vx[CHK_LOG2];

        r_d = '0;
        g_d = '0;
        b_d = '0;
        unique case (mode_d)
            2'd0: begin
                r_d = '0;
            end
            2'd1: begin
                r_d = {COLOR_W{~bar_q[1]}};
                g_d = {COLOR_W{~bar_q[2]}};
                b_d = {COLOR_W{~bar_q[0]}};
            end
            2'd2: begin
                r_d = {COLOR_W{chk}};
                g_d = {COLOR_W{chk}};
                b_d = {COLOR_W{chk}};
            end
            2'd3: begin
                r_d = solid_d[3*COLOR_W-1:2*COLOR_W];
                g_d = solid_d[2*COLOR_W-1:COLOR_W];
                b_d = solid_d[COLOR_W-1:0];
            end
        endcase
        if (!act) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            bpos_q  <= '0;
            bar_q   <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            act_q   <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hout_q  <= '0;
            vout_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            div_q <= div_d;
            fs_q  <= pen && first;
            if (pen) begin
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                bpos_q  <= bpos_d;
                bar_q   <= bar_d;
                mode_q  <= mode_d;
                solid_q <= solid_d;
                hsync_q <= hs ? HS_POL : ~HS_POL;
                vsync_q <= vs ? VS_POL : ~VS_POL;
                act_q   <= act;
                r_q     <= r_d;
                g_q     <= g_d;
                b_q     <= b_d;
                hout_q  <= hcnt_q;
                vout_q  <= vcnt_q;
            end
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_r           = r_q;
    assign o_g           = g_q;
    assign o_b           = b_q;
    assign o_vga_act     = act_q;
    assign o_hcnt        = hout_q;
    assign o_vcnt        = vout_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_syncgen_param.sv
// Bench for vga_syncgen_param: two small-timing instances checked every clk
// against a pixel-index reference model under random pattern changes and resets.
module tb_vga_syncgen_param;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hp, vp;
        int dv, chk;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  i_mode;
    logic [11:0] i_solid_rgb;

    logic       a_hs, a_vs, a_act, a_fs;
    logic [3:0] a_r, a_g, a_b;
    logic [4:0] a_h;
    logic [3:0] a_v;
    logic       b_hs, b_vs, b_act, b_fs;
    logic [3:0] b_r, b_g, b_b;
    logic [5:0] b_h;
    logic [3:0] b_v;

    cfg_t        cfg [2];
    logic [1:0]  m_mode [2];
    logic [11:0] m_solid [2];
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int vectors = 0;
    int miscompares = 0;
    int c = 0;

    always #5 clk = ~clk;

    vga_syncgen_param #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2),
        .COLOR_W(4), .CHK_LOG2(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
        .o_hsync(a_hs), .o_vsync(a_vs),
        .o_r(a_r), .o_g(a_g), .o_b(a_b),
        .o_vga_act(a_act), .o_hcnt(a_h), .o_vcnt(a_v),
        .o_frame_start(a_fs)
    );

    vga_syncgen_param #(
        .H_ACTIVE(24), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1),
        .COLOR_W(4), .CHK_LOG2(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
        .o_hsync(b_hs), .o_vsync(b_vs),
        .o_r(b_r), .o_g(b_g), .o_b(b_b),
        .o_vga_act(b_act), .o_hcnt(b_h), .o_vcnt(b_v),
        .o_frame_start(b_fs)
    );

    // c = clk edges since reset release; pixel k is produced on pen k+1.
    task automatic check_dut(input int d, input logic [31:0] obs);
        cfg_t        k;
        int          ht, vt, pens, p, h, v;
        bit          np;
        logic        hs, vs, act, fs;
        logic [11:0] rgb;
        logic [31:0] exp;
        k  = cfg[d];
        ht = k.ha + k.hfp + k.hsw + k.hbp;
        vt = k.va + k.vfp + k.vsw + k.vbp;
        pens = c / k.dv;
        if (pens == 0) begin
            exp = {~k.hp, ~k.vp, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00};
        end else begin
            p  = (pens - 1) % (ht * vt);
            h  = p % ht;
            v  = p / ht;
            np = (c % k.dv) == 0;
            if (np && p == 0) begin
                m_mode[d]  = i_mode;
                m_solid[d] = i_solid_rgb;
            end
            act = (h < k.ha) && (v < k.va);
            hs  = (h >= k.ha + k.hfp && h < k.ha + k.hfp + k.hsw) ? k.hp : ~k.hp;
            vs  = (v >= k.va + k.vfp && v < k.va + k.vfp + k.vsw) ? k.vp : ~k.vp;
            rgb = 12'h000;
            if (act) begin
                case (m_mode[d])
                    2'd1: rgb = bars[h / (k.ha / 8)];
                    2'd2: rgb = (((h >> k.chk) ^ (v >> k.chk)) & 1) != 0 ? 12'hFFF : 12'h000;
                    2'd3: rgb = m_solid[d];
                    default: rgb = 12'h000;
                endcase
            end
            fs  = np && (p == 0);
            exp = {hs, vs, act, fs, rgb, 8'(h), 8'(v)};
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL dut%0d c=%0d observed=%h expected=%h", d, c, obs, exp);
        end
    endtask

    task automatic check_all();
        check_dut(0, {a_hs, a_vs, a_act, a_fs, a_r, a_g, a_b, 8'(a_h), 8'(a_v)});
        check_dut(1, {b_hs, b_vs, b_act, b_fs, b_r, b_g, b_b, 8'(b_h), 8'(b_v)});
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rst_n) c++;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        cfg[0] = '{16, 2, 3, 3, 8, 1, 2, 2, 1'b0, 1'b0, 2, 2};
        cfg[1] = '{24, 3, 4, 5, 6, 2, 1, 3, 1'b1, 1'b1, 1, 3};
        m_mode  = '{2'd0, 2'd0};
        m_solid = '{12'h000, 12'h000};
        rst_n       = 1'b0;
        i_mode      = 2'd1;
        i_solid_rgb = 12'h000;
        run(4);
        rst_n = 1'b1;

        // Each mode for about a frame, with a mid-frame switch to the next.
        for (int m = 0; m < 4; m++) begin
            i_mode      = 2'(m);
            i_solid_rgb = 12'($urandom);
            run(300);
            i_mode      = 2'((m + 1) % 4);
            i_solid_rgb = 12'($urandom);
            run(400);
        end

        // Bars, then solid A5C mid-frame.
        i_mode = 2'd1;
        run(700);
        i_mode      = 2'd3;
        i_solid_rgb = 12'hA5C;
        run(1400);

        for (int i = 0; i < 3000; i++) begin
            cycle();
            if ($urandom_range(0, 149) == 0) begin
                i_mode      = 2'($urandom);
                i_solid_rgb = 12'($urandom);
            end
        end

        // Asynchronous reset away from any clock edge.
        #2;
        rst_n = 1'b0;
        c = 0;
        #1;
        check_all();
        run(3);
        i_mode = 2'd2;
        rst_n  = 1'b1;
        run(1500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
